// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// regfile_wr_arbiter: arbitrates the register-file write port between core
// writeback and debug, and sequences a one-register-per-cycle clear of x1..x31.
// Optional DBG anti-starvation: define REGFILE_ARB_STARVE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_wr_arbiter #(
  parameter int NREG = 32
`ifdef REGFILE_ARB_STARVE_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_req_i,
  output logic        clear_busy_o,
  output logic        core_stall_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  input  logic        dbg_valid_i,
  input  logic [4:0]  dbg_addr_i,
  input  logic [31:0] dbg_data_i,
  output logic        dbg_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

  state_t     state_q;
  logic [4:0] clr_idx_q;
  logic       w_wb_hit;
  logic       w_force_dbg;

  assign w_wb_hit = wb_valid_i && (wb_addr_i != 5'd0);

`ifdef REGFILE_ARB_STARVE_EN
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  logic [2:0] starve_q;
  // Force only with a live request so dbg_ready never asserts without dbg_valid.
  assign w_force_dbg = (starve_q == LIMIT) && dbg_valid_i;
`else
  assign w_force_dbg = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= 5'd1;
`ifdef REGFILE_ARB_STARVE_EN
      starve_q  <= 3'd0;
`endif
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_idx_q == LAST_IDX) begin
            state_q   <= ST_IDLE;
            clr_idx_q <= 5'd1;
          end else begin
            clr_idx_q <= clr_idx_q + 5'd1;
          end
`ifdef REGFILE_ARB_STARVE_EN
          starve_q <= 3'd0;
`endif
        end
        default: begin
          if (clear_req_i) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= 5'd1;
          end
`ifdef REGFILE_ARB_STARVE_EN
          if (dbg_valid_i && !dbg_ready_o)
            starve_q <= starve_q + 3'd1;
          else
            starve_q <= 3'd0;
`endif
        end
      endcase
    end
  end

  // Outputs are purely state + same-cycle inputs: the RF samples at mid-cycle.
  always_comb begin
    clear_busy_o = 1'b0;
    core_stall_o = 1'b0;
    dbg_ready_o  = 1'b0;
    rf_we_o      = 1'b0;
    rf_waddr_o   = 5'd0;
    rf_wdata_o   = 32'd0;
    if (reset) begin
      clear_busy_o = 1'b1;
      core_stall_o = 1'b1;
    end else if (state_q == ST_CLEAR) begin
      clear_busy_o = 1'b1;
      core_stall_o = 1'b1;
      rf_we_o      = 1'b1;
      rf_waddr_o   = clr_idx_q;
    end else if (w_wb_hit && !w_force_dbg) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = wb_addr_i;
      rf_wdata_o = wb_data_i;
    end else if (dbg_valid_i) begin
      core_stall_o = w_force_dbg;
      dbg_ready_o  = 1'b1;
      rf_we_o      = (dbg_addr_i != 5'd0);
      rf_waddr_o   = dbg_addr_i;
      rf_wdata_o   = dbg_data_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// tb_regfile_wr_arbiter: directed scoreboard bench for regfile_wr_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_req;
  logic        clear_busy;
  logic        core_stall;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        dbg_valid;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [40:0] exp;
  } sb_entry_t;

  sb_entry_t exp_q[$];

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .clear_req_i  (clear_req),
    .clear_busy_o (clear_busy),
    .core_stall_o (core_stall),
    .wb_valid_i   (wb_valid),
    .wb_addr_i    (wb_addr),
    .wb_data_i    (wb_data),
    .dbg_valid_i  (dbg_valid),
    .dbg_addr_i   (dbg_addr),
    .dbg_data_i   (dbg_data),
    .dbg_ready_o  (dbg_ready),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata)
  );

  // Packed as {clear_busy, core_stall, dbg_ready, rf_we, rf_waddr, rf_wdata}.
  function automatic logic [40:0] ex(input logic busy, input logic stall,
                                     input logic rdy, input logic we,
                                     input logic [4:0] a, input logic [31:0] d);
    return {busy, stall, rdy, we, a, d};
  endfunction

  task automatic step(input string tag, input logic [40:0] exp);
    sb_entry_t ent;
    logic [40:0] obs;
    ent.tag = tag;
    ent.exp = exp;
    exp_q.push_back(ent);
    @(negedge clk);
    ent = exp_q.pop_front();
    obs = {clear_busy, core_stall, dbg_ready, rf_we, rf_waddr, rf_wdata};
    checks++;
    assert (obs === ent.exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (busy,stall,rdy,we,addr,data)",
             ent.tag, obs, ent.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_run(input string tag, input int n);
    for (int i = 1; i <= n; i++)
      step(tag, ex(1'b1, 1'b1, 1'b0, 1'b1, 5'(i), 32'd0));
  endtask

  initial begin
    logic [40:0] rst_v;
    logic [40:0] idle_v;
    rst_v  = ex(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    idle_v = ex(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    reset = 1'b1; clear_req = 1'b0;
    wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    dbg_valid = 1'b0; dbg_addr = 5'd0; dbg_data = 32'd0;

    step("reset_c1", rst_v);
    step("reset_c2", rst_v);
    reset = 1'b0;
    clear_run("post_reset_clear", 31);
    step("post_reset_idle", idle_v);

    // WB beats DBG, then DBG is granted once WB drops.
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    dbg_valid = 1'b1; dbg_addr = 5'd6; dbg_data = 32'h0000_0066;
    step("wb_wins", ex(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF));
    wb_valid = 1'b0;
    step("dbg_granted", ex(1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h0000_0066));

    // x0 from both requesters: no write, DBG still acknowledged.
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
    dbg_addr = 5'd0; dbg_data = 32'h1;
    step("x0_drop", ex(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1));
    wb_valid = 1'b0; dbg_valid = 1'b0;
    step("idle_quiet", idle_v);

    // clear_req together with a WB write to x7; mid/last-cycle clear_req ignored.
    clear_req = 1'b1; wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    step("clear_req_wb_x7", ex(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h77));
    clear_req = 1'b0; wb_valid = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      clear_req = (i == 12 || i == 31);
      step("req_clear", ex(1'b1, 1'b1, 1'b0, 1'b1, 5'(i), 32'd0));
    end
    clear_req = 1'b0;
    step("req_clear_done", idle_v);

    // Reset during clear restarts the walk at x1.
    clear_req = 1'b1;
    step("clear_req_only", idle_v);
    clear_req = 1'b0;
    clear_run("pre_reset_clear", 10);
    reset = 1'b1;
    step("mid_clear_reset", rst_v);
    reset = 1'b0;
    clear_run("restart_clear", 31);
    step("restart_done", idle_v);

    // WB on x3 every cycle against a held DBG request on x9.
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    dbg_valid = 1'b1; dbg_addr = 5'd9; dbg_data = 32'h99;
    for (int i = 1; i <= 4; i++)
      step("starve_wb", ex(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h33));
`ifdef REGFILE_ARB_STARVE_EN
    step("starve_force", ex(1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h99));
    dbg_valid = 1'b0;
    step("starve_replay", ex(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h33));
`else
    for (int i = 5; i <= 10; i++)
      step("starve_never", ex(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h33));
`endif
    wb_valid = 1'b0; dbg_valid = 1'b0;
    step("final_idle", idle_v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Owns the single write port of the 32x32 integer register file and shares it between two requesters: core writeback (WB) and a debug/loader port (DBG).
- Sequences a hardware clear of x1..x31 after reset or on request. No register is written in parallel; the clear is one register per cycle.
- Stalls the core while clearing. Sits between the writeback stage, the debug unit and the register file.

Parameters:
- NREG, 32, number of architectural registers; the clear walks indices 1..NREG-1.
- STARVE_LIMIT, 4, consecutive refused DBG cycles before DBG is forced through (optional feature only).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- clear_req  in  1  pulse; starts a clear sequence when sampled in IDLE.
- clear_busy  out  1  high while in CLEAR.
- core_stall  out  1  core must hold PC and the WB request this cycle.
- wb_valid  in  1  core writeback request; cannot be back-pressured except by core_stall.
- wb_addr  in  5  WB destination register.
- wb_data  in  32  WB data.
- dbg_valid  in  1  debug write request; addr and data held stable until accepted.
- dbg_addr  in  5  debug destination register.
- dbg_data  in  32  debug data.
- dbg_ready  out  1  debug request is accepted this cycle.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.

Behaviour:
- FSM states are CLEAR and IDLE. A 5-bit clear index is held in clr_idx.
- reset high:
  - Next state is CLEAR, with clr_idx=1 and the starve counter at 0.
  - While reset is high, outputs are clear_busy=1, core_stall=1, rf_we=0, dbg_ready=0, rf_waddr=0, rf_wdata=0.
- CLEAR:
  - Outputs: rf_we=1, rf_waddr=clr_idx, rf_wdata=0, clear_busy=1, core_stall=1, dbg_ready=0.
  - clr_idx increments each cycle. Leaving the state on clr_idx==NREG-1 takes the next state to IDLE, so the clear lasts exactly 31 cycles.
  - clear_req is ignored while in CLEAR, including the last cycle.
- IDLE, outputs combinational from inputs:
  - core_stall=0 and clear_busy=0.
  - WB wins if wb_valid=1 and wb_addr!=0: rf_we=1, rf_waddr=wb_addr, rf_wdata=wb_data, dbg_ready=0.
  - Otherwise, if dbg_valid=1: dbg_ready=1. rf_we=(dbg_addr!=0), with rf_waddr=dbg_addr and rf_wdata=dbg_data.
  - A write to x0 from either requester is never driven (rf_we=0). WB to x0 does not occupy the port. DBG to x0 is acknowledged and dropped.
  - Otherwise rf_we=0, rf_waddr=0, rf_wdata=0.
  - clear_req=1 takes the next state to CLEAR with clr_idx=1. The write decided in that same cycle still completes.
- DBG handshake: a transfer occurs on a cycle with dbg_valid&dbg_ready. dbg_ready never asserts without dbg_valid.
- Reset mid-CLEAR restarts the clear at clr_idx=1. Reset mid-handshake drops the pending DBG request; the requester must re-present it.
- Write-port timing: the register file writes on the falling clock edge, so the arbiter's outputs must be stable by mid-cycle. All outputs are driven from state plus same-cycle inputs; no output is registered.

Optional Feature:
- Macro REGFILE_ARB_STARVE_EN.
- Defined:
  - A 3-bit starve counter increments in each IDLE cycle with dbg_valid=1 and dbg_ready=0, and clears on a DBG transfer or when dbg_valid=0.
  - When the counter equals STARVE_LIMIT in IDLE: core_stall=1, the WB write is suppressed, and DBG is granted as above (dbg_ready=1). The counter clears.
  - The core replays the same WB on the next cycle.
- Undefined: no counter; core_stall=1 only in CLEAR or reset; DBG can be starved indefinitely by back-to-back WB.

Test Plan:
- Reset held 2 cycles, then released: rf_we=1 for exactly 31 cycles with rf_waddr 1,2,...,31 and rf_wdata=0. core_stall=1 throughout, then clear_busy=0 and core_stall=0 on cycle 32.
- IDLE, wb_valid=1 wb_addr=5 wb_data=0xDEADBEEF together with dbg_valid=1 dbg_addr=6: rf_waddr=5, rf_wdata=0xDEADBEEF, dbg_ready=0. Next cycle wb_valid=0: dbg_ready=1, rf_waddr=6.
- wb_valid=1 wb_addr=0 plus dbg_valid=1 dbg_addr=0 dbg_data=0x1: rf_we=0 and dbg_ready=1 in the same cycle.
- clear_req pulsed in IDLE with wb write to x7 in that cycle: x7 is written, then 31 clear cycles follow. A clear_req issued mid-clear does not extend the sequence.
- Reset asserted on clear cycle 10 (rf_waddr=10): after release, the sequence restarts at rf_waddr=1 and again runs 31 cycles.
- With REGFILE_ARB_STARVE_EN, STARVE_LIMIT=4, WB writing x3 every cycle, and DBG held on x9: cycles 1-4 grant WB; cycle 5 gives core_stall=1, rf_waddr=9, dbg_ready=1; cycle 6 writes x3 again. Without the macro, DBG is never granted.
